// File: rtl/rtc_access_sched.sv
// DS1302 access scheduler: serialises host time-set requests and periodic time polls
// into single-byte commands for the byte engine, with per-command timeout.
module rtc_access_sched #(
    parameter int unsigned POLL_DIV = 2400000,
    parameter int unsigned TIMEOUT  = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic [7:0] wr_hour,
    input  logic [7:0] wr_minute,
    input  logic [7:0] wr_second,
    output logic       wr_ack,
    output logic       wr_done,
    output logic       eng_req,
    output logic       eng_write,
    output logic [7:0] eng_addr,
    output logic [7:0] eng_wdata,
    input  logic       eng_ack,
    input  logic [7:0] eng_rdata,
    output logic [7:0] rd_hour,
    output logic [7:0] rd_minute,
    output logic [7:0] rd_second,
    output logic       time_valid,
    output logic       busy,
    output logic       err
);

    localparam int unsigned PollW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_DIV - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle,
        StWWpOff,
        StWHour,
        StWMin,
        StWSec,
        StWWpOn,
        StRSec,
        StRMin,
        StRHour,
        StCommit
    } state_e;

    state_e           state_q, state_d;
    logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
    logic             poll_pend_q, poll_pend_d;
    logic             eng_req_q, eng_req_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             wr_ack_q, wr_done_q, wr_done_d;
    logic             time_valid_q, time_valid_d;
    logic             err_q, err_d;
    logic [7:0]       wr_hour_q, wr_min_q;
    logic [6:0]       wr_sec_q;
    logic [7:0]       sh_hour_q, sh_min_q;
    logic [6:0]       sh_sec_q;
    logic [7:0]       rd_hour_q, rd_min_q;
    logic [6:0]       rd_sec_q;

    logic poll_tick, ack_ok, timeout_hit, cmd_state, grant_wr, grant_poll;

    assign poll_tick   = (poll_cnt_q == PollLast);
    // An ack only counts while a command is actually outstanding.
    assign ack_ok      = eng_req_q & eng_ack;
    assign timeout_hit = eng_req_q & ~eng_ack & (wait_q == WaitLast);

    always_comb begin
        state_d      = state_q;
        grant_wr     = 1'b0;
        grant_poll   = 1'b0;
        wr_done_d    = 1'b0;
        time_valid_d = 1'b0;
        err_d        = 1'b0;
        cmd_state    = 1'b1;
        unique case (state_q)
            StIdle: begin
                cmd_state = 1'b0;
                if (wr_req) begin
                    grant_wr = 1'b1;
                    state_d  = StWWpOff;
                end else if (poll_pend_q) begin
                    grant_poll = 1'b1;
                    state_d    = StRSec;
                end
            end
            StWWpOff: if (ack_ok) state_d = StWHour;
            StWHour:  if (ack_ok) state_d = StWMin;
            StWMin:   if (ack_ok) state_d = StWSec;
            StWSec:   if (ack_ok) state_d = StWWpOn;
            StWWpOn: begin
                if (ack_ok) begin
                    state_d   = StIdle;
                    wr_done_d = 1'b1;
                end
            end
            StRSec:  if (ack_ok) state_d = StRMin;
            StRMin:  if (ack_ok) state_d = StRHour;
            StRHour: if (ack_ok) state_d = StCommit;
            StCommit: begin
                cmd_state    = 1'b0;
                time_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                cmd_state = 1'b0;
                state_d   = StIdle;
            end
        endcase
        if (timeout_hit) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end
    end

    // Request rises the cycle after state entry and falls the cycle after ack,
    // which guarantees a low cycle between consecutive commands.
    assign eng_req_d   = cmd_state & ~ack_ok & ~timeout_hit;
    assign wait_d      = eng_req_q ? wait_q + WaitW'(1) : '0;
    assign poll_cnt_d  = poll_tick ? '0 : poll_cnt_q + PollW'(1);
    assign poll_pend_d = poll_tick | (poll_pend_q & ~grant_poll);

    always_comb begin
        eng_write = 1'b0;
        eng_addr  = 8'h00;
        eng_wdata = 8'h00;
        case (state_q)
            StWWpOff: begin eng_write = 1'b1; eng_addr = 8'h8E; eng_wdata = 8'h00;             end
            StWHour:  begin eng_write = 1'b1; eng_addr = 8'h84; eng_wdata = wr_hour_q;         end
            StWMin:   begin eng_write = 1'b1; eng_addr = 8'h82; eng_wdata = wr_min_q;          end
            StWSec:   begin eng_write = 1'b1; eng_addr = 8'h80; eng_wdata = {1'b0, wr_sec_q};  end
            StWWpOn:  begin eng_write = 1'b1; eng_addr = 8'h8E; eng_wdata = 8'h80;             end
            StRSec:   eng_addr = 8'h81;
            StRMin:   eng_addr = 8'h83;
            StRHour:  eng_addr = 8'h85;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            poll_cnt_q   <= '0;
            poll_pend_q  <= 1'b0;
            eng_req_q    <= 1'b0;
            wait_q       <= '0;
            wr_ack_q     <= 1'b0;
            wr_done_q    <= 1'b0;
            time_valid_q <= 1'b0;
            err_q        <= 1'b0;
            wr_hour_q    <= '0;
            wr_min_q     <= '0;
            wr_sec_q     <= '0;
            sh_hour_q    <= '0;
            sh_min_q     <= '0;
            sh_sec_q     <= '0;
            rd_hour_q    <= '0;
            rd_min_q     <= '0;
            rd_sec_q     <= '0;
        end else begin
            state_q      <= state_d;
            poll_cnt_q   <= poll_cnt_d;
            poll_pend_q  <= poll_pend_d;
            eng_req_q    <= eng_req_d;
            wait_q       <= wait_d;
            wr_ack_q     <= grant_wr;
            wr_done_q    <= wr_done_d;
            time_valid_q <= time_valid_d;
            err_q        <= err_d;
            if (grant_wr) begin
                wr_hour_q <= wr_hour;
                wr_min_q  <= wr_minute;
                wr_sec_q  <= wr_second[6:0];
            end
            if (ack_ok) begin
                case (state_q)
                    StRSec:  sh_sec_q  <= eng_rdata[6:0];
                    StRMin:  sh_min_q  <= eng_rdata;
                    StRHour: sh_hour_q <= eng_rdata;
                    default: ;
                endcase
            end
            if (state_q == StCommit) begin
                rd_hour_q <= sh_hour_q;
                rd_min_q  <= sh_min_q;
                rd_sec_q  <= sh_sec_q;
            end
        end
    end

    assign wr_ack     = wr_ack_q;
    assign wr_done    = wr_done_q;
    assign eng_req    = eng_req_q;
    assign rd_hour    = rd_hour_q;
    assign rd_minute  = rd_min_q;
    assign rd_second  = {1'b0, rd_sec_q};
    assign time_valid = time_valid_q;
    assign busy       = (state_q != StIdle);
    assign err        = err_q;

endmodule

// File: tb/tb_rtc_access_sched.sv
// Bench for rtc_access_sched: engine model plus scoreboards for write commands and
// committed read times.
module tb_rtc_access_sched;

    localparam int unsigned PollDiv = 100;
    localparam int unsigned Timeout = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_req;
    logic [7:0] wr_hour, wr_minute, wr_second;
    logic       wr_ack, wr_done;
    logic       eng_req, eng_write;
    logic [7:0] eng_addr, eng_wdata;
    logic       eng_ack;
    logic [7:0] eng_rdata;
    logic [7:0] rd_hour, rd_minute, rd_second;
    logic       time_valid, busy, err;

    rtc_access_sched #(
        .POLL_DIV(PollDiv),
        .TIMEOUT (Timeout)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_hour   (wr_hour),
        .wr_minute (wr_minute),
        .wr_second (wr_second),
        .wr_ack    (wr_ack),
        .wr_done   (wr_done),
        .eng_req   (eng_req),
        .eng_write (eng_write),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .eng_ack   (eng_ack),
        .eng_rdata (eng_rdata),
        .rd_hour   (rd_hour),
        .rd_minute (rd_minute),
        .rd_second (rd_second),
        .time_valid(time_valid),
        .busy      (busy),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_cmd[$];
    logic [31:0] exp_time[$];
    logic [31:0] last_time = '0;

    // Engine model state
    logic [7:0] eng_sec, eng_min, eng_hour;
    logic [7:0] last_sec, last_min;
    logic [7:0] rd_addr_tbl[3];
    int         eng_delay = 5;
    bit         withhold = 1'b0;
    int         ecnt = 0;
    int         rd_idx = 0;

    // Monitor state
    int  cyc = 0;
    int  tv_cnt = 0, wr_done_cnt = 0, err_cnt = 0, poll_starts = 0;
    int  err_cyc = 0, rise_cyc = 0;
    bit  req_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle index = posedges since reset release.
    initial forever begin
        @(posedge clk);
        cyc = rst_n ? cyc + 1 : 0;
    end

    initial begin
        rd_addr_tbl[0] = 8'h81;
        rd_addr_tbl[1] = 8'h83;
        rd_addr_tbl[2] = 8'h85;
        eng_ack   = 1'b0;
        eng_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (eng_ack) begin
                eng_ack = 1'b0;
                ecnt    = 0;
            end else if (!eng_req || !rst_n) begin
                ecnt = 0;
            end else begin
                ecnt++;
                if (!withhold && ecnt == eng_delay) begin
                    eng_ack = 1'b1;
                    if (eng_write) begin
                        check("wr_cmd_expected", exp_cmd.size() > 0, 1);
                        if (exp_cmd.size() > 0)
                            check("wr_cmd_addr_data", {eng_addr, eng_wdata}, exp_cmd.pop_front());
                    end else begin
                        check("rd_cmd_addr", eng_addr, rd_addr_tbl[rd_idx]);
                        case (eng_addr)
                            8'h81: begin eng_rdata = eng_sec; last_sec = eng_sec; end
                            8'h83: begin eng_rdata = eng_min; last_min = eng_min; end
                            default: begin
                                eng_rdata = eng_hour;
                                exp_time.push_back({8'h00, eng_hour, last_min,
                                                    1'b0, last_sec[6:0]});
                            end
                        endcase
                        rd_idx = (rd_idx == 2) ? 0 : rd_idx + 1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (time_valid) begin
            tv_cnt++;
            check("tv_expected", exp_time.size() > 0, 1);
            if (exp_time.size() > 0) begin
                last_time = exp_time.pop_front();
                check("rd_time", {8'h00, rd_hour, rd_minute, rd_second}, last_time);
            end
        end
        if (wr_done) begin
            wr_done_cnt++;
            check("wr_seq_complete", exp_cmd.size(), 0);
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (eng_req && !req_prev) begin
            rise_cyc = cyc;
            if (eng_addr == 8'h81) poll_starts++;
        end
        req_prev = eng_req;
    end

    // what: 0 busy, 1 time_valid, 2 wr_done, 3 err, 4 in R_MIN, 5 in W_MIN
    task automatic wait_for(input string tag, input int what, input int limit);
        bit hit;
        int tv0, wd0, er0;
        hit = 1'b0;
        tv0 = tv_cnt;
        wd0 = wr_done_cnt;
        er0 = err_cnt;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            #1;
            case (what)
                0:       hit = busy;
                1:       hit = tv_cnt > tv0;
                2:       hit = wr_done_cnt > wd0;
                3:       hit = err_cnt > er0;
                4:       hit = eng_req && eng_addr == 8'h83;
                default: hit = eng_req && eng_addr == 8'h82;
            endcase
        end
        check(tag, hit, 1);
    endtask

    task automatic do_write(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input int dly);
        bit got;
        exp_cmd.push_back({8'h8E, 8'h00});
        exp_cmd.push_back({8'h84, h});
        exp_cmd.push_back({8'h82, m});
        exp_cmd.push_back({8'h80, 1'b0, s[6:0]});
        exp_cmd.push_back({8'h8E, 8'h80});
        @(negedge clk);
        wr_hour   = h;
        wr_minute = m;
        wr_second = s;
        wr_req    = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            #1;
            if (wr_ack) got = 1'b1;
        end
        check("wr_ack_seen", got, 1);
        eng_delay = dly;
        wr_req    = 1'b0;
        @(negedge clk);
        #1;
        check("wr_ack_one_cycle", wr_ack, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tv0, wd0, er0, ps0, next_tick;
        rst_n     = 1'b0;
        wr_req    = 1'b0;
        wr_hour   = 8'h00;
        wr_minute = 8'h00;
        wr_second = 8'h00;
        eng_sec   = 8'h59;
        eng_min   = 8'h30;
        eng_hour  = 8'h12;
        repeat (3) @(negedge clk);
        check("rst_rd", {8'h00, rd_hour, rd_minute, rd_second}, 0);
        check("rst_ctl", {busy, eng_req, eng_write, wr_ack, wr_done, time_valid, err}, 0);
        check("rst_eng", {eng_addr, eng_wdata}, 0);
        rst_n = 1'b1;

        // First poll and plain read
        wait_for("first_poll_start", 0, 300);
        check("first_poll_cycle", cyc, PollDiv + 1);
        wait_for("read1_tv", 1, 100);
        check("tv_count_1", tv_cnt, 1);

        // Clock-halt bit on the seconds byte must not reach rd_second
        eng_sec = 8'hD9;
        wait_for("read2_tv", 1, 200);
        check("tv_count_2", tv_cnt, 2);

        // Plain write sequence
        do_write(8'h23, 8'h45, 8'hD0, 5);
        wait_for("write1_done", 2, 200);
        check("wr_done_count_1", wr_done_cnt, 1);

        // Write arriving mid-read, slow engine so a poll tick lands during the write
        wait_for("reach_r_min", 4, 300);
        tv0 = tv_cnt;
        do_write(8'h08, 8'h15, 8'h42, 18);
        check("read_before_write", tv_cnt, tv0 + 1);
        wait_for("write2_done", 2, 300);
        eng_delay = 5;
        check("write2_no_poll_yet", tv_cnt, tv0 + 1);
        next_tick = (cyc / PollDiv + 1) * PollDiv;
        ps0 = poll_starts;
        for (int i = 0; i < 300 && cyc < next_tick; i++) @(negedge clk);
        check("merged_polls", poll_starts - ps0, 1);

        // Withheld ack on the next poll
        withhold = 1'b1;
        tv0 = tv_cnt;
        wait_for("timeout_err", 3, 200);
        check("timeout_latency", err_cyc - rise_cyc, Timeout);
        check("timeout_idle", {busy, eng_req}, 0);
        check("timeout_rd_kept", {8'h00, rd_hour, rd_minute, rd_second}, last_time);
        check("timeout_no_tv", tv_cnt, tv0);
        withhold = 1'b0;
        @(negedge clk);
        #1;
        check("err_one_cycle", err, 0);

        // Reset in the middle of a write
        do_write(8'h11, 8'h22, 8'h33, 5);
        wait_for("reach_w_min", 5, 200);
        wd0 = wr_done_cnt;
        er0 = err_cnt;
        tv0 = tv_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_rd", {8'h00, rd_hour, rd_minute, rd_second}, 0);
        check("midrst_ctl", {busy, eng_req, eng_write, wr_ack, wr_done, time_valid, err}, 0);
        check("midrst_eng", {eng_addr, eng_wdata}, 0);
        exp_cmd.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_for("post_rst_poll", 0, 300);
        check("post_rst_poll_cycle", cyc, PollDiv + 1);
        check("post_rst_no_wr_done", wr_done_cnt, wd0);
        check("post_rst_no_err", err_cnt, er0);
        check("post_rst_no_tv", tv_cnt, tv0);
        wait_for("post_rst_tv", 1, 100);
        check("exp_time_drained", exp_time.size(), 0);
        check("exp_cmd_drained", exp_cmd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
